// File: rtl/mem_responder_if.sv
// Memory handshake bundle between the control unit (master) and the memory (slave).
// AlignErr exists only when MEM_ALIGN_ERR_EN is defined.
`timescale 1ns/1ps
interface mem_responder_if #(
  parameter int ADDR_W = 9
);
  logic              MemEn;
  logic              RW;
  logic [1:0]        DataType;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
`ifdef MEM_ALIGN_ERR_EN
  logic              AlignErr;

  modport master (output MemEn, RW, DataType, Address, DataIn,
                  input  DataOut, MOC, AlignErr);
  modport slave  (input  MemEn, RW, DataType, Address, DataIn,
                  output DataOut, MOC, AlignErr);
`else
  modport master (output MemEn, RW, DataType, Address, DataIn,
                  input  DataOut, MOC);
  modport slave  (input  MemEn, RW, DataType, Address, DataIn,
                  output DataOut, MOC);
`endif
endinterface

// File: rtl/mem_responder.sv
// Big-endian byte-addressable memory answering the MemEn/RW/DataType handshake with MOC
// after LATENCY cycles. Define MEM_ALIGN_ERR_EN to reject misaligned accesses via AlignErr.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [1:0]        r_dtype;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [31:0]       r_dout;
  logic              r_moc;
  logic [7:0]        r_mem [DEPTH];

  logic              w_is_byte;
  logic              w_is_half;
  logic              w_misaligned;
  logic              w_fire;
  logic              w_we;
  logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [31:0]       w_rdata;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_is_byte = (r_dtype == 2'b01);
    w_is_half = (r_dtype == 2'b10);
    w_a0      = r_addr;
    if (w_is_half)       w_a0 = {r_addr[ADDR_W-1:1], 1'b0};
    else if (!w_is_byte) w_a0 = {r_addr[ADDR_W-1:2], 2'b00};
    w_a1 = w_a0 + ADDR_W'(1);
    w_a2 = w_a0 + ADDR_W'(2);
    w_a3 = w_a0 + ADDR_W'(3);

    w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    if (w_is_byte)      w_rdata = {24'h0, r_mem[w_a0]};
    else if (w_is_half) w_rdata = {16'h0, r_mem[w_a0], r_mem[w_a1]};

`ifdef MEM_ALIGN_ERR_EN
    w_misaligned = w_is_half ? r_addr[0] : (!w_is_byte && (r_addr[1:0] != 2'b00));
`else
    w_misaligned = 1'b0;
`endif
    w_fire = (r_state == BUSY) && (r_cnt == 4'd0);
    // Gating with reset drops a write whose completion edge coincides with reset.
    w_we   = w_fire && !r_rw && !w_misaligned && !reset;
  end

  // NOTE: the byte array has no reset; its contents must survive reset and clearing it would force flops.
  always_ff @(posedge clk) begin
    if (w_we) begin
      if (w_is_byte) begin
        r_mem[w_a0] <= r_din[7:0];
      end else if (w_is_half) begin
        r_mem[w_a0] <= r_din[15:8];
        r_mem[w_a1] <= r_din[7:0];
      end else begin
        r_mem[w_a0] <= r_din[31:24];
        r_mem[w_a1] <= r_din[23:16];
        r_mem[w_a2] <= r_din[15:8];
        r_mem[w_a3] <= r_din[7:0];
      end
    end
  end

`ifdef MEM_ALIGN_ERR_EN
  logic r_align_err;
  assign bus.AlignErr = r_align_err;
`endif

  // NOTE: sequential state uses non-blocking assignments so each branch reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rw        <= 1'b1;
      r_dtype     <= 2'b00;
      r_addr      <= '0;
      r_din       <= '0;
      r_dout      <= '0;
      r_moc       <= 1'b0;
`ifdef MEM_ALIGN_ERR_EN
      r_align_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.MemEn) begin
            r_rw    <= bus.RW;
            r_dtype <= bus.DataType;
            r_addr  <= bus.Address;
            r_din   <= bus.DataIn;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_moc <= 1'b1;
            if (r_rw && !w_misaligned) r_dout <= w_rdata;
`ifdef MEM_ALIGN_ERR_EN
            r_align_err <= w_misaligned;
`endif
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          if (!bus.MemEn) begin
            r_moc   <= 1'b0;
`ifdef MEM_ALIGN_ERR_EN
            r_align_err <= 1'b0;
`endif
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.DataOut = r_dout;
  assign bus.MOC     = r_moc;
endmodule
